button_event_decoder: RTL and testbench

- Sits directly downstream of the button debouncer; consumes its clean, synchronised, active-high pressed level.
- Classifies each gesture as a short press, a long press or a double press.
- Emits a one-cycle pulse per event and keeps a running event counter.
- Feeds mode-select and menu logic so consumers never handle raw press timing.

---
 rtl/button_event_decoder.sv | 138 +++++++++++++
 tb/tb_button_event_decoder.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - short/long/double press classifier with event counter (optional auto-repeat: BUTTON_REPEAT_EN)
module button_event_decoder #(
  parameter int LONG_COUNTS   = 50_000_000,
  parameter int DOUBLE_COUNTS = 15_000_000,
  parameter int REPEAT_COUNTS = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_level,
  output logic       short_press,
  output logic       long_press,
  output logic       double_press,
  output logic       held,
  output logic [7:0] event_count
);

  localparam int MAX_LD  = (LONG_COUNTS > DOUBLE_COUNTS) ? LONG_COUNTS : DOUBLE_COUNTS;
  localparam int MAX_ALL = (MAX_LD > REPEAT_COUNTS) ? MAX_LD : REPEAT_COUNTS;
  localparam int TIMER_W = $clog2(MAX_ALL) + 1;

  localparam logic [TIMER_W-1:0] LONG_LAST   = TIMER_W'(LONG_COUNTS - 1);
  localparam logic [TIMER_W-1:0] DOUBLE_LAST = TIMER_W'(DOUBLE_COUNTS - 1);
`ifdef BUTTON_REPEAT_EN
  localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_COUNTS - 1);
`endif

  typedef enum logic [2:0] {
    S_WAIT_RELEASE,
    S_IDLE,
    S_PRESSED,
    S_LONG_HELD,
    S_WAIT_SECOND,
    S_SECOND_PRESSED
  } state_t;

  state_t               r_state;
  logic [TIMER_W-1:0]   r_timer;
  logic                 r_short;
  logic                 r_long;
  logic                 r_double;
  logic                 r_held;
  logic [7:0]           r_count;

  // Gesture FSM: timer, registered event pulses, held level and event counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_WAIT_RELEASE;
      r_timer  <= '0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_held   <= 1'b0;
      r_count  <= 8'd0;
    end else begin
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_timer  <= r_timer + TIMER_W'(1);
      case (r_state)
        S_WAIT_RELEASE: begin
          // a button already down at reset must be released before it can count
          if (!button_level) begin
            r_state <= S_IDLE;
            r_timer <= '0;
          end
        end
        S_IDLE: begin
          if (button_level) begin
            r_state <= S_PRESSED;
            r_timer <= '0;
          end
        end
        S_PRESSED: begin
          // release takes priority over reaching the long threshold on the same edge
          if (!button_level) begin
            r_state <= S_WAIT_SECOND;
            r_timer <= '0;
          end else if (r_timer == LONG_LAST) begin
            r_state <= S_LONG_HELD;
            r_timer <= '0;
            r_long  <= 1'b1;
            r_held  <= 1'b1;
            r_count <= r_count + 8'd1;
          end
        end
        S_LONG_HELD: begin
          if (!button_level) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_held  <= 1'b0;
          end
`ifdef BUTTON_REPEAT_EN
          else if (r_timer == REPEAT_LAST) begin
            r_timer <= '0;
            r_long  <= 1'b1;
            r_count <= r_count + 8'd1;
          end
`else
          else begin
            r_timer <= r_timer;
          end
`endif
        end
        S_WAIT_SECOND: begin
          // a second press on the timeout edge still counts as a double press
          if (button_level) begin
            r_state <= S_SECOND_PRESSED;
            r_timer <= '0;
          end else if (r_timer == DOUBLE_LAST) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_short <= 1'b1;
            r_count <= r_count + 8'd1;
          end
        end
        S_SECOND_PRESSED: begin
          if (!button_level) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_double <= 1'b1;
            r_count  <= r_count + 8'd1;
          end
        end
        default: begin
          r_state <= S_WAIT_RELEASE;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign short_press  = r_short;
  assign long_press   = r_long;
  assign double_press = r_double;
  assign held         = r_held;
  assign event_count  = r_count;

endmodule

// File: tb/tb_button_event_decoder.sv
// tb/tb_button_event_decoder.sv - self-checking bench for button_event_decoder
module tb_button_event_decoder;

  localparam int LONG_C   = 20;
  localparam int DOUBLE_C = 8;
  localparam int REPEAT_C = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       button_level = 1'b0;
  logic       short_press;
  logic       long_press;
  logic       double_press;
  logic       held;
  logic [7:0] event_count;

  int errors = 0;
  int checks = 0;

  // reference model: run lengths of high/low samples per gesture
  bit         m_armed, m_pending, m_second, m_long_hold;
  int         m_hi, m_lo;
  logic       m_short, m_long, m_double, m_held;
  logic [7:0] m_count;

  int n_short, n_long, n_double;

  always #5 clk = ~clk;

  button_event_decoder #(
    .LONG_COUNTS  (LONG_C),
    .DOUBLE_COUNTS(DOUBLE_C),
    .REPEAT_COUNTS(REPEAT_C)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .button_level(button_level),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .held        (held),
    .event_count (event_count)
  );

  task automatic model_step(input logic b, input logic r);
    m_short = 1'b0; m_long = 1'b0; m_double = 1'b0;
    if (r) begin
      m_armed = 0; m_pending = 0; m_second = 0; m_long_hold = 0;
      m_hi = 0; m_lo = 0; m_held = 1'b0; m_count = 8'd0;
      return;
    end
    if (!m_armed) begin
      if (!b) m_armed = 1;
      m_hi = 0; m_lo = 0;
      return;
    end
    if (b) begin
      m_lo = 0;
      m_hi++;
      if (m_hi == 1 && m_pending) begin
        m_pending = 0;
        m_second  = 1;
      end
      if (!m_second) begin
        if (m_hi == LONG_C + 1) begin
          m_long = 1'b1; m_long_hold = 1; m_held = 1'b1;
        end
`ifdef BUTTON_REPEAT_EN
        else if (m_long_hold && ((m_hi - LONG_C - 1) % REPEAT_C) == 0) begin
          m_long = 1'b1;
        end
`endif
      end
    end else begin
      m_lo++;
      if (m_hi > 0) begin
        if (m_second) begin
          m_double = 1'b1; m_second = 0;
        end else if (m_long_hold) begin
          m_long_hold = 0; m_held = 1'b0;
        end else begin
          m_pending = 1;
        end
      end
      m_hi = 0;
      if (m_pending && m_lo == DOUBLE_C + 1) begin
        m_short = 1'b1; m_pending = 0;
      end
    end
    if (m_short || m_long || m_double) m_count = m_count + 8'd1;
  endtask

  task automatic tick(input logic b, input logic r);
    button_level = b;
    reset        = r;
    @(posedge clk);
    #1;
    model_step(b, r);
    n_short  += int'(short_press);
    n_long   += int'(long_press);
    n_double += int'(double_press);
  endtask

  task automatic start_clean();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    n_short = 0; n_long = 0; n_double = 0;
  endtask

  task automatic test_reset();
    logic lv[$];
    tick(1'b1, 1'b1);
    n_short = 0; n_long = 0; n_double = 0;
    checks++;
    if ({short_press, long_press, double_press, held, event_count} !== 12'd0) begin
      errors++;
      $display("FAIL reset_state: got %b want 0", {short_press, long_press, double_press, held, event_count});
    end
    repeat (25) lv.push_back(1'b1);
    repeat (3)  lv.push_back(1'b0);
    repeat (2)  lv.push_back(1'b1);
    repeat (12) lv.push_back(1'b0);
    foreach (lv[i]) begin
      tick(lv[i], 1'b0);
      checks++;
      if ({short_press, long_press, double_press, held, event_count} !== {m_short, m_long, m_double, m_held, m_count}) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got %b want %b", i,
                 {short_press, long_press, double_press, held, event_count}, {m_short, m_long, m_double, m_held, m_count});
      end
      if (i == 27) begin
        checks++;
        if (n_short + n_long + n_double != 0 || event_count !== 8'd0) begin
          errors++;
          $display("FAIL reset_no_events: got pulses=%0d count=%0d want 0", n_short + n_long + n_double, event_count);
        end
      end
    end
    checks++;
    if (n_short != 1) begin
      errors++;
      $display("FAIL reset_then_idle: got shorts=%0d want 1", n_short);
    end
  endtask

  task automatic test_short();
    logic lv[$];
    start_clean();
    repeat (5)  lv.push_back(1'b1);
    repeat (20) lv.push_back(1'b0);
    foreach (lv[i]) begin
      tick(lv[i], 1'b0);
      checks++;
      if ({short_press, long_press, double_press, held, event_count} !== {m_short, m_long, m_double, m_held, m_count}) begin
        errors++;
        $display("FAIL short cyc %0d: got %b want %b", i,
                 {short_press, long_press, double_press, held, event_count}, {m_short, m_long, m_double, m_held, m_count});
      end
      checks++;
      if (short_press !== ((i == 5 + DOUBLE_C) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL short_latency cyc %0d: got %b", i, short_press);
      end
    end
    checks++;
    if (n_short != 1 || event_count !== 8'd1) begin
      errors++;
      $display("FAIL short_total: got shorts=%0d count=%0d want 1/1", n_short, event_count);
    end
  endtask

  task automatic test_long();
    logic lv[$];
    int   want_cnt;
`ifdef BUTTON_REPEAT_EN
    want_cnt = 3;
`else
    want_cnt = 1;
`endif
    start_clean();
    repeat (31) lv.push_back(1'b1);
    repeat (12) lv.push_back(1'b0);
    foreach (lv[i]) begin
      tick(lv[i], 1'b0);
      checks++;
      if ({short_press, long_press, double_press, held, event_count} !== {m_short, m_long, m_double, m_held, m_count}) begin
        errors++;
        $display("FAIL long cyc %0d: got %b want %b", i,
                 {short_press, long_press, double_press, held, event_count}, {m_short, m_long, m_double, m_held, m_count});
      end
      checks++;
      if (held !== ((i >= LONG_C && i <= 30) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL long_held cyc %0d: got %b", i, held);
      end
      if (i == LONG_C) begin
        checks++;
        if (long_press !== 1'b1) begin
          errors++;
          $display("FAIL long_latency: got %b want 1", long_press);
        end
      end
    end
    checks++;
    if (n_long != want_cnt || n_short != 0 || n_double != 0 || event_count !== 8'(want_cnt)) begin
      errors++;
      $display("FAIL long_total: got long=%0d short=%0d double=%0d count=%0d want long=%0d count=%0d",
               n_long, n_short, n_double, event_count, want_cnt, want_cnt);
    end
  endtask

  task automatic test_double();
    logic lv[$];
    start_clean();
    repeat (3)  lv.push_back(1'b1);
    repeat (4)  lv.push_back(1'b0);
    repeat (3)  lv.push_back(1'b1);
    repeat (12) lv.push_back(1'b0);
    foreach (lv[i]) begin
      tick(lv[i], 1'b0);
      checks++;
      if ({short_press, long_press, double_press, held, event_count} !== {m_short, m_long, m_double, m_held, m_count}) begin
        errors++;
        $display("FAIL double cyc %0d: got %b want %b", i,
                 {short_press, long_press, double_press, held, event_count}, {m_short, m_long, m_double, m_held, m_count});
      end
      if (i == 10) begin
        checks++;
        if (double_press !== 1'b1) begin
          errors++;
          $display("FAIL double_edge: got %b want 1", double_press);
        end
      end
    end
    checks++;
    if (n_double != 1 || n_short != 0 || event_count !== 8'd1) begin
      errors++;
      $display("FAIL double_total: got double=%0d short=%0d count=%0d want 1/0/1", n_double, n_short, event_count);
    end
  endtask

  task automatic test_boundary();
    logic lv[$];
    // release on the long-threshold edge
    start_clean();
    repeat (LONG_C) lv.push_back(1'b1);
    repeat (12)     lv.push_back(1'b0);
    foreach (lv[i]) begin
      tick(lv[i], 1'b0);
      checks++;
      if ({short_press, long_press, double_press, held, event_count} !== {m_short, m_long, m_double, m_held, m_count}) begin
        errors++;
        $display("FAIL bnd_long cyc %0d: got %b want %b", i,
                 {short_press, long_press, double_press, held, event_count}, {m_short, m_long, m_double, m_held, m_count});
      end
    end
    checks++;
    if (n_long != 0 || n_short != 1) begin
      errors++;
      $display("FAIL bnd_long_total: got long=%0d short=%0d want 0/1", n_long, n_short);
    end
    // second press on the double-timeout edge
    start_clean();
    lv = {};
    repeat (3)        lv.push_back(1'b1);
    repeat (DOUBLE_C) lv.push_back(1'b0);
    repeat (3)        lv.push_back(1'b1);
    repeat (12)       lv.push_back(1'b0);
    foreach (lv[i]) begin
      tick(lv[i], 1'b0);
      checks++;
      if ({short_press, long_press, double_press, held, event_count} !== {m_short, m_long, m_double, m_held, m_count}) begin
        errors++;
        $display("FAIL bnd_double cyc %0d: got %b want %b", i,
                 {short_press, long_press, double_press, held, event_count}, {m_short, m_long, m_double, m_held, m_count});
      end
    end
    checks++;
    if (n_double != 1 || n_short != 0) begin
      errors++;
      $display("FAIL bnd_double_total: got double=%0d short=%0d want 1/0", n_double, n_short);
    end
  endtask

  task automatic test_wrap_and_reset();
    start_clean();
    for (int p = 0; p < 256; p++) begin
      for (int c = 0; c < 2 + DOUBLE_C + 2; c++) begin
        tick((c < 2) ? 1'b1 : 1'b0, 1'b0);
        checks++;
        if ({short_press, long_press, double_press, held, event_count} !== {m_short, m_long, m_double, m_held, m_count}) begin
          errors++;
          $display("FAIL wrap p%0d c%0d: got %b want %b", p, c,
                   {short_press, long_press, double_press, held, event_count}, {m_short, m_long, m_double, m_held, m_count});
        end
      end
    end
    checks++;
    if (event_count !== 8'd0 || n_short != 256) begin
      errors++;
      $display("FAIL wrap_total: got count=%0d shorts=%0d want 0/256", event_count, n_short);
    end
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    checks++;
    if ({short_press, long_press, double_press, held, event_count} !== 12'd0) begin
      errors++;
      $display("FAIL midpress_reset: got %b want 0", {short_press, long_press, double_press, held, event_count});
    end
    n_short = 0; n_long = 0; n_double = 0;
    repeat (30) tick(1'b0, 1'b0);
    checks++;
    if (n_short + n_long + n_double != 0 || event_count !== 8'd0) begin
      errors++;
      $display("FAIL midpress_discard: got pulses=%0d count=%0d want 0", n_short + n_long + n_double, event_count);
    end
  endtask

  task automatic test_random();
    logic b;
    int   seg;
    start_clean();
    b = 1'b0;
    seg = 0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        b   = ~b;
        seg = $urandom_range(1, 34);
      end
      seg--;
      tick(b, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
      checks++;
      if ({short_press, long_press, double_press, held, event_count} !== {m_short, m_long, m_double, m_held, m_count}) begin
        errors++;
        $display("FAIL random cyc %0d: got %b want %b", i,
                 {short_press, long_press, double_press, held, event_count}, {m_short, m_long, m_double, m_held, m_count});
      end
      checks++;
      if (int'(short_press) + int'(long_press) + int'(double_press) > 1) begin
        errors++;
        $display("FAIL random_onehot cyc %0d: got %b%b%b", i, short_press, long_press, double_press);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_double();
    test_boundary();
    test_wrap_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
